// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared sizes, mult/div latencies and the Tuse/Tnew hazard test
package hazard_scoreboard_pkg;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int TW = 2;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC = 10;
  localparam int CW = 16;
  localparam int TIW = $clog2(DIV_CYC + 1);
  function automatic logic hazard(logic [TW-1:0] tuse, logic [TW-1:0] tnew);
    return tuse < tnew;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_xalu_busy_timer.sv
// xalu_busy_timer: loadable mult/div busy down-counter
module xalu_busy_timer
  import hazard_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic load_mul,
  input  logic load_div,
  output logic busy
);
  logic [TIW-1:0] t;
  always_ff @(posedge clk)
    if (!reset || flush) t <= '0;
    else if (load_mul) t <= TIW'(MULT_CYC);
    else if (load_div) t <= TIW'(DIV_CYC);
    else if (t != '0) t <= t - 1'b1;
  assign busy = t != '0;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage stall generator with per-register Tnew scoreboard and mult/div busy timer
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic          d_we,
  input  logic [AW-1:0] d_a3,
  input  logic [TW-1:0] d_tnew,
  input  logic [3:0]    d_xalu_op,
  input  logic          d_xalu_mul,
  input  logic          d_xalu_div,
  output logic          stall,
  output logic          stall_rs,
  output logic          stall_rt,
  output logic          stall_xalu,
  output logic          xalu_busy,
  output logic [CW-1:0] stall_cnt
);
  logic [TW-1:0] cnt [NREG];
  logic issue;
  assign stall_rs = d_valid & (d_rs != '0) & hazard(d_tuse_rs, cnt[d_rs]);
  assign stall_rt = d_valid & (d_rt != '0) & hazard(d_tuse_rt, cnt[d_rt]);
  assign stall_xalu = d_valid & (d_xalu_op != '0) & xalu_busy;
  assign stall = stall_rs | stall_rt | stall_xalu;
  assign issue = d_valid & ~stall & ~flush;
  always_ff @(posedge clk)
    if (!reset || flush) for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    else for (int r = 0; r < NREG; r++)
      cnt[r] <= (issue && d_we && d_a3 == AW'(r) && r != 0) ? d_tnew
              : (cnt[r] != '0 ? cnt[r] - 1'b1 : '0);
  always_ff @(posedge clk)
    if (!reset) stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  xalu_busy_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .load_mul (issue & d_xalu_mul),
    .load_div (issue & d_xalu_div),
    .busy     (xalu_busy)
  );
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed table, corner sequences and random stimulus against a time-based model
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;
  logic clk = 0, reset = 0, flush = 0, d_valid = 0, d_we = 0, d_xalu_mul = 0, d_xalu_div = 0;
  logic [AW-1:0] d_rs = 0, d_rt = 0, d_a3 = 0;
  logic [TW-1:0] d_tuse_rs = 0, d_tuse_rt = 0, d_tnew = 0;
  logic [3:0] d_xalu_op = 0;
  logic stall, stall_rs, stall_rt, stall_xalu, xalu_busy;
  logic [CW-1:0] stall_cnt;
  always #5 clk = ~clk;
  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_we(d_we), .d_a3(d_a3), .d_tnew(d_tnew),
    .d_xalu_op(d_xalu_op), .d_xalu_mul(d_xalu_mul), .d_xalu_div(d_xalu_div),
    .stall(stall), .stall_rs(stall_rs), .stall_rt(stall_rt), .stall_xalu(stall_xalu),
    .xalu_busy(xalu_busy), .stall_cnt(stall_cnt)
  );
  typedef struct {
    logic v; logic [4:0] rs, rt; logic [1:0] tr, tt; logic we; logic [4:0] a3; logic [1:0] tn;
    logic [3:0] op; logic mul, div, fl, rn, es, eb;
  } vec_t;
  int total = 0, bad = 0, cyc = 0;
  int ready [32];
  int busy_until = -1;
  int sc = 0;
  vec_t tbl [$];
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", n, cyc, act, exp);
    end
  endtask
  function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic [1:0] tr, logic [1:0] tt,
                              logic we, logic [4:0] a3, logic [1:0] tn, logic [3:0] op, logic mul,
                              logic div, logic es, logic eb);
    vec_t x;
    x.v = v; x.rs = rs; x.rt = rt; x.tr = tr; x.tt = tt; x.we = we; x.a3 = a3; x.tn = tn;
    x.op = op; x.mul = mul; x.div = div; x.fl = 0; x.rn = 1; x.es = es; x.eb = eb;
    return x;
  endfunction
  function automatic vec_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic int remaining(int r);
    return (r == 0 || ready[r] <= cyc) ? 0 : ready[r] - cyc;
  endfunction
  task automatic clear_model();
    for (int r = 0; r < 32; r++) ready[r] = 0;
    busy_until = -1;
  endtask
  task automatic apply(vec_t x);
    bit s_rs, s_rt, s_x, s, busy;
    @(negedge clk);
    d_valid = x.v; d_rs = x.rs; d_rt = x.rt; d_tuse_rs = x.tr; d_tuse_rt = x.tt; d_we = x.we;
    d_a3 = x.a3; d_tnew = x.tn; d_xalu_op = x.op; d_xalu_mul = x.mul; d_xalu_div = x.div;
    flush = x.fl; reset = x.rn;
    cyc++;
    #2;
    busy = busy_until >= cyc;
    s_rs = x.v && x.rs != 0 && int'(x.tr) < remaining(x.rs);
    s_rt = x.v && x.rt != 0 && int'(x.tt) < remaining(x.rt);
    s_x = x.v && x.op != 0 && busy;
    s = s_rs | s_rt | s_x;
    chk("stall_rs", stall_rs, s_rs);
    chk("stall_rt", stall_rt, s_rt);
    chk("stall_xalu", stall_xalu, s_x);
    chk("stall", stall, s);
    chk("xalu_busy", xalu_busy, busy);
    chk("stall_cnt", stall_cnt, sc);
    if (!x.rn) begin
      clear_model();
      sc = 0;
    end else begin
      if (s && sc < 65535) sc++;
      if (x.fl) clear_model();
      else if (x.v && !s) begin
        if (x.we && x.a3 != 0) ready[x.a3] = cyc + 1 + int'(x.tn);
        if (x.mul) busy_until = cyc + MULT_CYC;
        else if (x.div) busy_until = cyc + DIV_CYC;
      end
    end
  endtask
  initial begin
    vec_t x;
    clear_model();
    x = idle(); x.rn = 0;
    apply(x); apply(x);
    apply(idle());
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_busy", xalu_busy, 0);
    tbl.push_back(mk(1, 1, 0, 1, 2, 1, 2, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 4, 1, 1, 1, 3, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 2, 4, 1, 1, 1, 3, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2, 1, 2, 2, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 3, 3, 1, 31, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 31, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 31, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 31, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 31, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 0, 3, 3, 1, 8, 1, 2, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 3, 3, 1, 8, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 3, 0, 1, 0, 0));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 0, 0, 3, 3, 1, 9, 1, 2, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 3, 3, 1, 9, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2, 1, 5, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2, 1, 6, 2, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 0, 6, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 6, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2, 1, 0, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      chk("tbl_stall", stall, tbl[i].es);
      chk("tbl_busy", xalu_busy, tbl[i].eb);
    end
    apply(mk(1, 0, 0, 1, 1, 0, 0, 0, 3, 0, 1, 0, 0));
    apply(idle());
    apply(mk(1, 0, 0, 1, 2, 1, 7, 2, 0, 0, 0, 0, 0));
    x = idle(); x.fl = 1;
    apply(x);
    chk("pre_flush_busy", xalu_busy, 1);
    apply(mk(1, 7, 7, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    chk("post_flush_stall", stall, 0);
    chk("post_flush_busy", xalu_busy, 0);
    apply(mk(1, 0, 0, 1, 1, 0, 0, 0, 3, 0, 1, 0, 0));
    apply(idle());
    x = mk(1, 0, 0, 3, 3, 1, 9, 1, 2, 0, 0, 1, 1); x.rn = 0;
    apply(x);
    chk("rst_mid_stall", stall, 1);
    apply(mk(1, 0, 0, 3, 3, 1, 9, 1, 2, 0, 0, 0, 0));
    chk("post_rst_stall", stall, 0);
    chk("post_rst_busy", xalu_busy, 0);
    chk("post_rst_cnt", stall_cnt, 0);
    for (int i = 0; i < 600; i++) begin
      int k;
      k = $urandom_range(0, 15);
      x = mk($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             2'($urandom), 2'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 2'($urandom),
             0, k == 0, k == 1, 0, 0);
      x.op = (k < 2) ? 4'(k + 1) : (k < 5 ? 4'd2 : 4'd0);
      x.fl = $urandom_range(0, 29) == 0;
      x.rn = $urandom_range(0, 59) != 0;
      apply(x);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
